// File: rtl/div_ctrl_pkg.sv
// Shared defines for the EX-stage divider requester: controller state codes
// and the divider start/ready handshake levels.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_CANCEL = 2'd3
   } div_state_e;

   localparam logic DIV_START     = 1'b1;
   localparam logic DIV_STOP      = 1'b0;
   localparam logic DIV_READY     = 1'b1;
   localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_ctrl.sv
// EX-stage requester for the multi-cycle divider: issues one division per
// DIV/DIVU, stalls EX until the result lands, and cancels on flush.
// Optional: DIV_FAST_ZERO_EN resolves zero divisors locally without the divider.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] src_a_i,
   input  logic [31:0] src_b_i,
   input  logic        flush_i,
   input  logic        ex_advance_i,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        result_valid_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_opa_o,
   output logic [31:0] div_opb_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i
);

   div_state_e  state_q, state_d;
   logic [31:0] opa_q, opb_q, hi_q, lo_q;
   logic        sgn_q, rv_q, drain_q;
   logic        req_ok, fast_zero, stall_c, done_c;

   assign req_ok = div_req_i & ~flush_i;

`ifdef DIV_FAST_ZERO_EN
   assign fast_zero = req_ok & (src_b_i == 32'd0);
`else
   assign fast_zero = 1'b0;
`endif

   assign done_c = (state_q == ST_BUSY) & ~flush_i & (div_ready_i == DIV_READY);

   always_comb begin
      state_d     = state_q;
      div_start_o = DIV_STOP;
      div_annul_o = 1'b0;
      stall_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stall_c = req_ok;
            if (req_ok) state_d = fast_zero ? ST_HOLD : ST_BUSY;
         end
         ST_BUSY: begin
            stall_c = 1'b1;
            if (flush_i) begin
               div_annul_o = 1'b1;
               state_d     = ST_CANCEL;
            end else begin
               div_start_o = DIV_START;
               if (div_ready_i == DIV_READY) state_d = ST_HOLD;
            end
         end
         // result stays parked until EX moves on; requests here are the same instruction
         ST_HOLD:   if (ex_advance_i | flush_i) state_d = ST_IDLE;
         ST_CANCEL: if (drain_q) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // the IDLE stall is combinational off the request, so mask it while in reset
   assign stall_o        = stall_c & rst;
   assign hi_o           = hi_q;
   assign lo_o           = lo_q;
   assign result_valid_o = rv_q;
   assign div_signed_o   = sgn_q;
   assign div_opa_o      = opa_q;
   assign div_opb_o      = opb_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         rv_q    <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == ST_CANCEL) ? ~drain_q : 1'b0;
         if ((state_q == ST_IDLE) && req_ok) begin
            opa_q <= src_a_i;
            opb_q <= src_b_i;
            sgn_q <= div_signed_i;
         end
         if (done_c) begin
            hi_q <= div_result_i[63:32];
            lo_q <= div_result_i[31:0];
            rv_q <= 1'b1;
         end else if ((state_q == ST_IDLE) && fast_zero) begin
            hi_q <= '0;
            lo_q <= '0;
            rv_q <= 1'b1;
         end else if ((state_q == ST_HOLD) && (ex_advance_i | flush_i)) begin
            rv_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural divider (34 cycles of
// start for nonzero divisors, 2 for zero) and a result scoreboard.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        div_req_i = 1'b0, div_signed_i = 1'b0, flush_i = 1'b0, ex_advance_i = 1'b0;
   logic [31:0] src_a_i = '0, src_b_i = '0;
   logic        stall_o, result_valid_o, div_start_o, div_annul_o, div_signed_o;
   logic [31:0] hi_o, lo_o, div_opa_o, div_opb_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   int          checks = 0, errors = 0, starts = 0;
   logic        start_prev = 1'b0;
   logic [63:0] sb[$];
   int          dcnt;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk(clk), .rst(rst), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .src_a_i(src_a_i), .src_b_i(src_b_i), .flush_i(flush_i), .ex_advance_i(ex_advance_i),
      .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .result_valid_o(result_valid_o),
      .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_result_i(div_result_i),
      .div_ready_i(div_ready_i)
   );

   // divider model: result is ready once start has been seen for the latency
   always @(posedge clk or negedge rst) begin
      if (!rst) dcnt <= 0;
      else if (div_start_o) dcnt <= dcnt + 1;
      else dcnt <= 0;
   end

   assign div_ready_i = div_start_o && (dcnt >= ((div_opb_o == 32'd0) ? 2 : 34));

   always_comb begin
      div_result_i = '0;
      if (div_opb_o != 32'd0) begin
         if (div_signed_o)
            div_result_i = {32'($signed(div_opa_o) % $signed(div_opb_o)),
                            32'($signed(div_opa_o) / $signed(div_opb_o))};
         else
            div_result_i = {div_opa_o % div_opb_o, div_opa_o / div_opb_o};
      end
   end

   always @(negedge clk) begin
      if (div_start_o && !start_prev) starts++;
      start_prev = div_start_o;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int estall, input int hold);
      int          n_stall = 0;
      int          t = 0;
      int          s0;
      logic        ok = 1'b1;
      logic [63:0] snap;
      sb.push_back({ehi, elo});
      s0 = starts;
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = sg; src_a_i = a; src_b_i = b;
      while (t < 100) begin
         @(negedge clk);
         if (result_valid_o) break;
         if (stall_o) n_stall++;
         t++;
         @(posedge clk); #1;
      end
      chk("timeout", 64'(t < 100), 64'd1);
      chk("stall_cycles", 64'(n_stall), 64'(estall));
      chk("result", {hi_o, lo_o}, sb.pop_front());
      snap = {hi_o, lo_o};
      repeat (hold) begin
         @(negedge clk);
         ok = ok & result_valid_o & ~stall_o & ({hi_o, lo_o} == snap);
      end
      chk("hold_stable", 64'(ok), 64'd1);
      @(posedge clk); #1;
      ex_advance_i = 1'b1; div_req_i = 1'b0;
      @(posedge clk); #1;
      ex_advance_i = 1'b0;
      @(negedge clk);
      chk("rv_clear", 64'(result_valid_o), 64'd0);
      chk("start_count", 64'(starts - s0), (estall == 1) ? 64'd0 : 64'd1);
   endtask

   initial begin
      div_req_i = 1'b1; src_a_i = 32'd9; src_b_i = 32'd3;
      #12;
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_outs", {result_valid_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
      chk("rst_hilo", {hi_o, lo_o}, 64'd0);
      chk("rst_ops", {div_opa_o, div_opb_o}, 64'd0);
      div_req_i = 1'b0;
      @(posedge clk); #1 rst = 1'b1;

      do_div(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 36, 1);
      do_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 36, 1);
      do_div(1'b0, 32'hFFFFFF9C, 32'd7, 32'd2, 32'h24924916, 36, 1);
`ifdef DIV_FAST_ZERO_EN
      do_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1, 1);
`else
      do_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 4, 1);
`endif

      // flush in IDLE alongside a request: nothing issues
      @(posedge clk); #1;
      div_req_i = 1'b1; flush_i = 1'b1; src_a_i = 32'd8; src_b_i = 32'd2;
      @(negedge clk);
      chk("idle_flush_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      div_req_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("idle_flush_start", 64'(div_start_o), 64'd0);

      // flush in BUSY, new request held through CANCEL, then back-to-back issue
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = 1'b1; src_a_i = 32'd50; src_b_i = 32'd3;
      repeat (10) @(posedge clk);
      #1 flush_i = 1'b1; div_req_i = 1'b0;
      @(negedge clk);
      chk("annul_pulse", {div_annul_o, div_start_o}, 64'b10);
      @(posedge clk); #1;
      flush_i = 1'b0; div_req_i = 1'b1; src_a_i = 32'd100; src_b_i = 32'd7;
      @(negedge clk);
      chk("cancel1", {stall_o, div_annul_o, result_valid_o, div_start_o}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cancel2", {stall_o, div_start_o}, 64'd0);
      do_div(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 36, 1);

      // result parked with EX held and the request still asserted
      do_div(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 36, 5);

      // asynchronous reset mid-BUSY
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = 1'b1; src_a_i = 32'd77; src_b_i = 32'd5;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_ctl", {stall_o, result_valid_o, div_start_o, div_annul_o, div_signed_o}, 64'd0);
      chk("mid_rst_ops", {div_opa_o, div_opb_o}, 64'd0);
      chk("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1; div_req_i = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {stall_o, div_start_o}, 64'd0);
      do_div(1'b0, 32'd77, 32'd5, 32'd2, 32'd15, 36, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
